// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with a READY/START/DONE handshake.
//
// Single-cycle ops (FWD, ADD, AND, OR, SUB, reserved codes) complete on the accept edge.
// Shifts and rotate move one bit per edge. MUL is shift-add over WIDTH edges, one
// multiplier bit per edge. The accept edge performs the first step, so an n-step op shows
// DONE n cycles after it is accepted.
//
// Ports:
//   CLK     - clock, rising edge
//   RESET   - synchronous, active-low reset
//   START   - request, taken only while READY=1
//   SELECT  - operation code, sampled on accept
//   DATA1   - operand A, sampled on accept
//   DATA2   - operand B / shift amount, sampled on accept
//   READY   - block can accept a request this cycle
//   DONE    - one-cycle pulse: RESULT and flags were just updated
//   RESULT  - registered result, held until the next DONE
//   ZERO    - registered: last written RESULT was zero
//   CARRY   - registered: ADD carry-out, SUB not-borrow, 0 otherwise
//   ILLEGAL - registered: last completed op used a reserved SELECT
module seq_alu #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [3:0]       SELECT,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic             READY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             CARRY,
  output logic             ILLEGAL
);

  localparam logic [3:0] OpFwd = 4'h0;
  localparam logic [3:0] OpAdd = 4'h1;
  localparam logic [3:0] OpAnd = 4'h2;
  localparam logic [3:0] OpOr  = 4'h3;
  localparam logic [3:0] OpSub = 4'h4;
  localparam logic [3:0] OpSll = 4'h5;
  localparam logic [3:0] OpSrl = 4'h6;
  localparam logic [3:0] OpSra = 4'h7;
  localparam logic [3:0] OpRor = 4'h8;
  localparam logic [3:0] OpMul = 4'h9;

  localparam logic [SHW:0] MulSteps = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] OneStep  = (SHW+1)'(1);

  typedef enum logic [1:0] {StIdle, StShift, StMul} state_e;

  state_e           state_q, state_d;
  logic [3:0]       sel_q, sel_d;
  logic [WIDTH-1:0] work_q, work_d;     // shift operand, or multiplicand for MUL
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW:0]     cnt_q, cnt_d;       // steps still to perform, including this edge's
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             illegal_q, illegal_d;
  logic             done_q, done_d;

  logic             accept;
  logic [3:0]       op;
  logic [WIDTH-1:0] src, mpl, acc, shifted, acc_next;
  logic [SHW:0]     steps;
  logic             last, is_shift;
  logic [WIDTH:0]   sum;
  logic             fin, fin_carry, fin_illegal;
  logic [WIDTH-1:0] fin_res;

  assign accept = (state_q == StIdle) && START;

  // Operands of the current step: live inputs on the accept edge, latched copies after.
  always_comb begin
    if (state_q == StIdle) begin
      op    = SELECT;
      src   = DATA1;
      mpl   = DATA2;
      acc   = '0;
      steps = (SELECT == OpMul) ? MulSteps : {1'b0, DATA2[SHW-1:0]};
    end else begin
      op    = sel_q;
      src   = work_q;
      mpl   = mplier_q;
      acc   = acc_q;
      steps = cnt_q;
    end
  end

  assign is_shift = op inside {OpSll, OpSrl, OpSra, OpRor};
  assign last     = (steps == OneStep);
  assign acc_next = acc + (mpl[0] ? src : '0);

  always_comb begin
    case (op)
      OpSll:   shifted = {src[WIDTH-2:0], 1'b0};
      OpSrl:   shifted = {1'b0, src[WIDTH-1:1]};
      OpSra:   shifted = {src[WIDTH-1], src[WIDTH-1:1]};
      default: shifted = {src[0], src[WIDTH-1:1]};
    endcase
  end

  // SUB as A + ~B + 1 so the carry-out reads as "no borrow".
  always_comb begin
    if (op == OpSub) begin
      sum = {1'b0, src} + {1'b0, ~mpl} + (WIDTH+1)'(1);
    end else begin
      sum = {1'b0, src} + {1'b0, mpl};
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (START) begin
          if (SELECT == OpMul) begin
            state_d = StMul;
          end else if (is_shift && (steps != '0) && !last) begin
            state_d = StShift;
          end
        end
      end
      StShift, StMul: begin
        if (last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state.
  always_comb begin
    sel_d       = sel_q;
    work_d      = work_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    illegal_d   = illegal_q;
    done_d      = 1'b0;
    fin         = 1'b0;
    fin_res     = result_q;
    fin_carry   = 1'b0;
    fin_illegal = 1'b0;

    if (accept) sel_d = SELECT;

    if (accept || (state_q != StIdle)) begin
      if (is_shift) begin
        if (steps == '0) begin
          fin     = 1'b1;
          fin_res = src;
        end else if (last) begin
          fin     = 1'b1;
          fin_res = shifted;
        end else begin
          work_d = shifted;
          cnt_d  = steps - OneStep;
        end
      end else if (op == OpMul) begin
        if (last) begin
          fin     = 1'b1;
          fin_res = acc_next;
        end else begin
          work_d   = {src[WIDTH-2:0], 1'b0};
          mplier_d = {1'b0, mpl[WIDTH-1:1]};
          acc_d    = acc_next;
          cnt_d    = steps - OneStep;
        end
      end else begin
        fin = 1'b1;
        case (op)
          OpFwd: fin_res = mpl;
          OpAdd, OpSub: begin
            fin_res   = sum[WIDTH-1:0];
            fin_carry = sum[WIDTH];
          end
          OpAnd: fin_res = src & mpl;
          OpOr:  fin_res = src | mpl;
          default: begin
            fin_res     = result_q;
            fin_illegal = 1'b1;
          end
        endcase
      end
    end

    if (fin) begin
      result_d  = fin_res;
      zero_d    = (fin_res == '0);
      carry_d   = fin_carry;
      illegal_d = fin_illegal;
      done_d    = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      sel_q     <= '0;
      work_q    <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      carry_q   <= 1'b0;
      illegal_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      work_q    <= work_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      illegal_q <= illegal_d;
      done_q    <= done_d;
    end
  end

  // Outputs.
  always_comb begin
    READY   = (state_q == StIdle);
    DONE    = done_q;
    RESULT  = result_q;
    ZERO    = zero_q;
    CARRY   = carry_q;
    ILLEGAL = illegal_q;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised multi-cycle successor to the 8-bit combinational ALU. It keeps the FORWARD/ADD/AND/OR encodings and adds SUB, iterative shifts and rotate (one bit per cycle), and an iterative shift-add multiply. A READY/START/DONE handshake and a registered RESULT and flags let the control unit stall on long operations. It sits between the register file read ports and the write-back path.

Parameters:
WIDTH, 8, operand and result width in bits (>= 4, power of 2)
SHW, $clog2(WIDTH), shift-amount width (derived; do not override)

Ports:
CLK  input  1  clock; all state updates on rising edge
RESET  input  1  synchronous, active-low reset
START  input  1  request; accepted only on an edge where READY=1
SELECT  input  4  operation code, sampled on accept
DATA1  input  WIDTH  operand A, sampled on accept
DATA2  input  WIDTH  operand B / shift amount, sampled on accept
READY  output  1  block can accept a request this cycle
DONE  output  1  one-cycle pulse: RESULT and flags valid and updated
RESULT  output  WIDTH  registered result, held until the next DONE
ZERO  output  1  registered; 1 when the RESULT written at DONE is 0
CARRY  output  1  registered; carry-out for ADD, NOT borrow for SUB, 0 for other ops
ILLEGAL  output  1  registered; 1 when the completed op had a reserved SELECT

Behaviour:
- Clock is CLK; reset is synchronous and active-low (RESET=0 at a rising edge resets).
- Reset values: state=IDLE, READY=1, DONE=0, RESULT=0, ZERO=1, CARRY=0, ILLEGAL=0. Reset mid-operation aborts the operation; no DONE is produced for it.
- States: IDLE, SHIFT, MUL.
- IDLE: READY=1. On an edge with START=1, latch SELECT/DATA1/DATA2 (accept edge).
- Single-cycle ops (FWD 0000, ADD 0001, AND 0010, OR 0011, SUB 0100, reserved): RESULT and flags are written at the accept edge. DONE=1 in the following cycle. State stays IDLE.
- FWD: RESULT=DATA2. ADD: {CARRY,RESULT}=DATA1+DATA2. SUB: DATA1+~DATA2+1; CARRY=1 means no borrow. AND/OR are bitwise. All arithmetic is modulo 2^WIDTH.
- Shifts: SLL 0101, SRL 0110, SRA 0111, ROR 1000. The amount is n=DATA2[SHW-1:0]; upper DATA2 bits are ignored.
  - If n=0: behaves as a single-cycle op with RESULT=DATA1.
  - Otherwise: go to SHIFT with counter=n. Each edge shifts the working register by 1 and decrements the counter.
  - The edge where the counter goes 1->0 writes RESULT and returns to IDLE. DONE is high in the next cycle.
  - Latency from accept edge to DONE cycle is n cycles.
  - SRA replicates the MSB; ROR rotates LSB into MSB.
- MUL 1001: go to MUL. Shift-add over WIDTH edges, one multiplier bit per edge, LSB first.
  - RESULT = low WIDTH bits of DATA1*DATA2 (unsigned); the high half is discarded.
  - DONE arrives WIDTH cycles after the accept edge.
- Reserved SELECT (1010-1111): single-cycle. RESULT is unchanged, ILLEGAL=1, ZERO reflects the held RESULT, CARRY=0. ILLEGAL is cleared by the next completed legal op.
- READY=0 in SHIFT and MUL. START is ignored while READY=0; no queuing.
- DONE is high exactly one cycle per accepted op. The DONE cycle is in IDLE with READY=1, so a START in that cycle is accepted (back-to-back, no bubble).
- ZERO/CARRY/ILLEGAL change only on the edge that produces DONE (or reset). They are stable otherwise.
- Operands are latched at accept; DATA1/DATA2/SELECT changes during SHIFT/MUL have no effect.

Test Plan:
- Reset: hold RESET=0 two edges, release -> READY=1, DONE=0, RESULT=0x00, ZERO=1, CARRY=0, ILLEGAL=0.
- WIDTH=8, START with ADD 0xF0+0x20 -> next cycle DONE=1, RESULT=0x10, CARRY=1, ZERO=0. Then SUB 0x05-0x05 in the DONE cycle -> next cycle RESULT=0x00, ZERO=1, CARRY=1.
- SRA DATA1=0x90, DATA2=0xFB (n=3) -> READY=0 for 2 cycles, DONE in 3rd cycle after accept, RESULT=0xF2. A START pulse with ADD during busy is ignored (exactly one DONE).
- MUL 0x0D*0x0B -> DONE 8 cycles after accept, RESULT=0x8F. Then MUL 0x10*0x10 -> RESULT=0x00, ZERO=1.
- ROR 0x01 by 1 -> RESULT=0x80. Then SLL with n=0 on 0x5A -> 1-cycle DONE, RESULT=0x5A.
- SELECT=1111 after RESULT=0x8F -> DONE, RESULT=0x8F, ILLEGAL=1. Then MUL started, RESET=0 asserted 3 cycles in -> no DONE, all outputs at reset values next cycle.
